// File: rtl/systolic_weight_seq_pkg.sv
// Shared sizing defaults and FSM state encoding for the weight-load sequencer.
package systolic_weight_seq_pkg;

    localparam int DEF_PE_ROW     = 8;
    localparam int DEF_PE_COL     = 8;
    localparam int DEF_BIT_ROW_ID = 3;
    localparam int DEF_DATA_W     = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } State_t;

endpackage

// File: rtl/systolic_weight_seq.sv
// Weight-load sequencer: drains one weight tile row by row from the weight
// buffer and issues aligned row ID / column enable / data to systolic_loader_w.
module systolic_weight_seq
    import systolic_weight_seq_pkg::*;
#(
    parameter int PE_ROW     = DEF_PE_ROW,
    parameter int PE_COL     = DEF_PE_COL,
    parameter int BIT_ROW_ID = DEF_BIT_ROW_ID,
    parameter int DATA_W     = DEF_DATA_W
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     i_Start,
    input  logic                     i_Abort,
    input  logic [BIT_ROW_ID:0]      i_Num_Rows,
    input  logic [PE_COL-1:0]        i_Col_Mask,
    input  logic                     i_Wbuf_Valid,
    input  logic [PE_COL*DATA_W-1:0] i_Wbuf_Data,
    output logic                     o_Wbuf_Ready,
    output logic [BIT_ROW_ID-1:0]    o_Systolic_En_ID,
    output logic [PE_COL-1:0]        o_Systolic_En_W,
    output logic [PE_COL*DATA_W-1:0] o_Weight_Data,
    output logic                     o_Busy,
    output logic                     o_Done
);

    localparam int CNT_W = BIT_ROW_ID + 1;

    State_t                    r_State;
    logic [BIT_ROW_ID-1:0]     r_Row_Cnt;
    logic [CNT_W-1:0]          r_Num_Rows;
    logic [PE_COL-1:0]         r_Mask;
    logic                      r_Wbuf_Ready;
    logic                      r_Busy;
    logic                      r_Done;
    logic [BIT_ROW_ID-1:0]     r_En_ID;
    logic [PE_COL-1:0]         r_En_W;
    logic [PE_COL*DATA_W-1:0]  r_Weight_Data;

    logic [CNT_W-1:0]          w_Num_Rows_Sat;
    logic                      w_Last_Row;

    // Oversized tiles are clipped to the physical array height.
    assign w_Num_Rows_Sat = (i_Num_Rows > CNT_W'(PE_ROW)) ? CNT_W'(PE_ROW) : i_Num_Rows;
    assign w_Last_Row     = ({1'b0, r_Row_Cnt} == (r_Num_Rows - CNT_W'(1)));

    // Ready and busy are registered alongside each state change so they
    // always equal a decode of the current state with no input-to-output path.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_State       <= ST_IDLE;
            r_Row_Cnt     <= '0;
            r_Num_Rows    <= '0;
            r_Mask        <= '0;
            r_Wbuf_Ready  <= 1'b0;
            r_Busy        <= 1'b0;
            r_Done        <= 1'b0;
            r_En_ID       <= '0;
            r_En_W        <= '0;
            r_Weight_Data <= '0;
        end else begin
            r_En_W <= '0;
            r_Done <= 1'b0;
            case (r_State)
                ST_IDLE: begin
                    if (i_Start && !i_Abort) begin
                        r_Num_Rows <= w_Num_Rows_Sat;
                        r_Mask     <= i_Col_Mask;
                        r_Row_Cnt  <= '0;
                        r_Busy     <= 1'b1;
                        if (w_Num_Rows_Sat == '0) begin
                            r_State <= ST_DONE;
                        end else begin
                            r_State      <= ST_LOAD;
                            r_Wbuf_Ready <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_Abort) begin
                        r_State      <= ST_IDLE;
                        r_Wbuf_Ready <= 1'b0;
                        r_Busy       <= 1'b0;
                    end else if (i_Wbuf_Valid) begin
                        r_En_ID       <= r_Row_Cnt;
                        r_En_W        <= r_Mask;
                        r_Weight_Data <= i_Wbuf_Data;
                        r_Row_Cnt     <= r_Row_Cnt + BIT_ROW_ID'(1);
                        if (w_Last_Row) begin
                            r_State      <= ST_DONE;
                            r_Wbuf_Ready <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    r_State <= ST_IDLE;
                    r_Busy  <= 1'b0;
                    r_Done  <= !i_Abort;
                end
                default: begin
                    r_State      <= ST_IDLE;
                    r_Wbuf_Ready <= 1'b0;
                    r_Busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_Wbuf_Ready     = r_Wbuf_Ready;
    assign o_Systolic_En_ID = r_En_ID;
    assign o_Systolic_En_W  = r_En_W;
    assign o_Weight_Data    = r_Weight_Data;
    assign o_Busy           = r_Busy;
    assign o_Done           = r_Done;

endmodule

// File: tb/tb_systolic_weight_seq.sv
// Self-checking bench for systolic_weight_seq: directed tiles plus random traffic
// compared cycle by cycle against a tile-level behavioural model.
module tb_systolic_weight_seq;

    localparam int PR = 8;
    localparam int PC = 8;
    localparam int RW = 3;
    localparam int DW = 8;

    logic                CLK = 1'b0;
    logic                RST_N = 1'b0;
    logic                iStart = 1'b0;
    logic                iAbort = 1'b0;
    logic [RW:0]         iNumRows = '0;
    logic [PC-1:0]       iMask = '0;
    logic                iValid = 1'b0;
    logic [PC*DW-1:0]    iData = '0;
    logic                oReady;
    logic [RW-1:0]       oEnId;
    logic [PC-1:0]       oEnW;
    logic [PC*DW-1:0]    oData;
    logic                oBusy;
    logic                oDone;

    int checkCount = 0;
    int errorCount = 0;
    int issuedRows = 0;
    int doneSeen   = 0;

    // Behavioural model: a tile is "loading" while rows remain, then spends one
    // cycle finishing before the done pulse.
    bit               mLoading;
    bit               mFinishing;
    int               mRow;
    int               mCount;
    logic [PC-1:0]    mMask;
    logic [RW-1:0]    expId;
    logic [PC-1:0]    expEnW;
    logic [PC*DW-1:0] expData;
    bit               expDone;

    systolic_weight_seq dut (
        .CLK              (CLK),
        .RST_N            (RST_N),
        .i_Start          (iStart),
        .i_Abort          (iAbort),
        .i_Num_Rows       (iNumRows),
        .i_Col_Mask       (iMask),
        .i_Wbuf_Valid     (iValid),
        .i_Wbuf_Data      (iData),
        .o_Wbuf_Ready     (oReady),
        .o_Systolic_En_ID (oEnId),
        .o_Systolic_En_W  (oEnW),
        .o_Weight_Data    (oData),
        .o_Busy           (oBusy),
        .o_Done           (oDone)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit start, input bit abort, input int num,
                                 input logic [PC-1:0] mask, input bit valid);
        iStart   = start;
        iAbort   = abort;
        iNumRows = (RW+1)'(num);
        iMask    = mask;
        iValid   = valid;
        iData    = {$urandom, $urandom};
    endtask

    task automatic modelReset();
        mLoading   = 0;
        mFinishing = 0;
        mRow       = 0;
        mCount     = 0;
        mMask      = '0;
        expId      = '0;
        expEnW     = '0;
        expData    = '0;
        expDone    = 0;
    endtask

    task automatic modelEdge();
        expEnW  = '0;
        expDone = 0;
        if (mLoading) begin
            if (iAbort) begin
                mLoading = 0;
            end else if (iValid) begin
                expEnW  = mMask;
                expId   = RW'(mRow);
                expData = iData;
                mRow++;
                if (mRow == mCount) begin
                    mLoading   = 0;
                    mFinishing = 1;
                end
            end
        end else if (mFinishing) begin
            expDone    = !iAbort;
            mFinishing = 0;
        end else if (iStart && !iAbort) begin
            mCount = (int'(iNumRows) > PR) ? PR : int'(iNumRows);
            mMask  = iMask;
            mRow   = 0;
            if (mCount == 0) mFinishing = 1;
            else mLoading = 1;
        end
    endtask

    task automatic cycle();
        modelEdge();
        @(posedge CLK);
        #1;
        checkOutput("ready", 64'(oReady), 64'(mLoading));
        checkOutput("busy",  64'(oBusy),  64'(mLoading || mFinishing));
        checkOutput("done",  64'(oDone),  64'(expDone));
        checkOutput("enW",   64'(oEnW),   64'(expEnW));
        checkOutput("enId",  64'(oEnId),  64'(expId));
        checkOutput("data",  oData,       expData);
        if (oEnW != '0) issuedRows++;
        if (oDone) doneSeen++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, '0, 0);
            cycle();
        end
    endtask

    task automatic startTile(input int num, input logic [PC-1:0] mask);
        applyStimulus(1, 0, num, mask, 0);
        cycle();
    endtask

    task automatic tileTotals(input string tag, input int rows, input int dones);
        checkOutput({tag, "_rows"}, 64'(issuedRows), 64'(rows));
        checkOutput({tag, "_dones"}, 64'(doneSeen), 64'(dones));
        issuedRows = 0;
        doneSeen   = 0;
    endtask

    initial begin
        modelReset();
        repeat (2) @(posedge CLK);
        #1;
        checkOutput("rst_ready", 64'(oReady), 64'd0);
        checkOutput("rst_busy",  64'(oBusy),  64'd0);
        checkOutput("rst_done",  64'(oDone),  64'd0);
        checkOutput("rst_enW",   64'(oEnW),   64'd0);
        checkOutput("rst_enId",  64'(oEnId),  64'd0);
        checkOutput("rst_data",  oData,       64'd0);
        RST_N = 1'b1;
        idleCycles(2);

        // Full tile, valid held high
        startTile(8, 8'hFF);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
            cycle();
        end
        idleCycles(3);
        tileTotals("full", 8, 1);

        // Short tile with toggling valid
        startTile(3, 8'h0F);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 0, 0, '0, (i % 2) == 0);
            cycle();
        end
        idleCycles(3);
        tileTotals("toggle", 3, 1);

        // Empty tile, then oversized tile clipped to the array height
        startTile(0, 8'hAA);
        idleCycles(3);
        tileTotals("empty", 0, 1);
        startTile(12, 8'h3C);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
            cycle();
        end
        idleCycles(3);
        tileTotals("sat", 8, 1);

        // Start during load is ignored; abort drops the presented beat
        startTile(5, 8'hF0);
        applyStimulus(0, 0, 0, '0, 1);
        cycle();
        applyStimulus(1, 0, 1, 8'h01, 0);
        cycle();
        applyStimulus(0, 0, 0, '0, 1);
        cycle();
        applyStimulus(0, 1, 0, '0, 1);
        cycle();
        idleCycles(3);
        tileTotals("abort", 2, 0);

        // Back-to-back tiles: second start in the idle cycle after DONE
        startTile(2, 8'h11);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
            cycle();
        end
        idleCycles(1);
        startTile(3, 8'h22);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
            cycle();
        end
        idleCycles(3);
        tileTotals("b2b", 5, 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                          int'($urandom_range(0, 15)), PC'($urandom),
                          $urandom_range(0, 9) < 7);
            cycle();
        end
        applyStimulus(0, 1, 0, '0, 0);
        cycle();
        idleCycles(2);
        issuedRows = 0;
        doneSeen   = 0;

        // Asynchronous reset while row 3 of 8 is being presented
        startTile(8, 8'hFF);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(0, 0, 0, '0, 1);
            cycle();
        end
        applyStimulus(0, 0, 0, '0, 1);
        #3;
        RST_N = 1'b0;
        #1;
        checkOutput("arst_ready", 64'(oReady), 64'd0);
        checkOutput("arst_busy",  64'(oBusy),  64'd0);
        checkOutput("arst_done",  64'(oDone),  64'd0);
        checkOutput("arst_enW",   64'(oEnW),   64'd0);
        checkOutput("arst_enId",  64'(oEnId),  64'd0);
        checkOutput("arst_data",  oData,       64'd0);
        modelReset();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        issuedRows = 0;
        doneSeen   = 0;
        idleCycles(6);
        tileTotals("arst", 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
